us_replicate_3x3: RTL

US_REPLICATE_3X3 -- requirements
Module: us_replicate_3x3

---
 rtl/us_replicate_3x3.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/us_replicate_3x3.sv
// us_replicate_3x3: 3x nearest-neighbour video upscaler.
// Input lines are written into two ping-pong line banks. A reader FSM replays
// each full bank as three identical output lines, each input pixel held for
// three output pixels, with HBLANK blank cycles after every output line.

module us_replicate_3x3 #(
    parameter int WIDTH   = 10,
    parameter int HACT_IN = 10,
    parameter int VACT_IN = 10,
    parameter int HBLANK  = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_vsync,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_r_data,
    input  logic [WIDTH-1:0] i_g_data,
    input  logic [WIDTH-1:0] i_b_data,
    output logic             o_vsync,
    output logic             o_hsync,
    output logic             o_de,
    output logic [WIDTH-1:0] o_r_data,
    output logic [WIDTH-1:0] o_g_data,
    output logic [WIDTH-1:0] o_b_data
);

    localparam int XW = (HACT_IN > 1) ? $clog2(HACT_IN) : 1;
    localparam int YW = $clog2(VACT_IN + 1);
    localparam int BW = $clog2(HBLANK);
    localparam int PW = 3 * WIDTH;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_ACTIVE = 2'd1,
        RD_BLANK  = 2'd2
    } rd_state_t;

    // Two line banks, one packed {r,g,b} word per input pixel.
    logic [PW-1:0] line_mem [0:1][0:HACT_IN-1];

    // Frame / writer state
    logic          vsync_prev_q, vsync_prev_d;
    logic          armed_q, armed_d;
    logic          wr_bank_q, wr_bank_d;
    logic [XW-1:0] wr_x_q, wr_x_d;
    logic [YW-1:0] wr_y_q, wr_y_d;
    logic [1:0]    full_q, full_d;
    logic          ready_q, ready_d;

    // Reader state
    rd_state_t     state_q, state_d;
    logic          rd_bank_q, rd_bank_d;
    logic [XW-1:0] rd_x_q, rd_x_d;
    logic [1:0]    rep_q, rep_d;
    logic [1:0]    row_rep_q, row_rep_d;
    logic [BW-1:0] blank_cnt_q, blank_cnt_d;
    logic          frame_start_q, frame_start_d;

    // Registered outputs
    logic          de_q, de_d;
    logic          vs_q, vs_d;
    logic          hs_q, hs_d;
    logic [PW-1:0] pix_q, pix_d;

    logic          vsync_rise;
    logic          accept;
    logic [1:0]    full_set;
    logic [1:0]    full_clr;

    assign vsync_rise = i_vsync & ~vsync_prev_q;

    // The only unregistered term on o_ready: a pixel offered in the same cycle
    // as a frame-start edge must be refused, so the edge masks the registered
    // ready combinationally.
    assign o_ready = ready_q & ~vsync_rise;
    assign accept  = i_valid & o_ready;

    assign o_de     = de_q;
    assign o_vsync  = vs_q;
    assign o_hsync  = hs_q;
    assign o_r_data = pix_q[3*WIDTH-1:2*WIDTH];
    assign o_g_data = pix_q[2*WIDTH-1:WIDTH];
    assign o_b_data = pix_q[WIDTH-1:0];

    // Line-buffer write port; contents are intentionally never reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_mem[wr_bank_q][wr_x_q] <= {i_r_data, i_g_data, i_b_data};
        end
    end

    // Writer: arm on frame start, fill the write bank, hand it over when full.
    always_comb begin
        vsync_prev_d = i_vsync;
        armed_d      = armed_q;
        wr_bank_d    = wr_bank_q;
        wr_x_d       = wr_x_q;
        wr_y_d       = wr_y_q;
        full_set     = 2'b00;
        if (vsync_rise) begin
            armed_d   = 1'b1;
            wr_bank_d = 1'b0;
            wr_x_d    = '0;
            wr_y_d    = '0;
        end else if (accept) begin
            if (wr_x_q == XW'(HACT_IN - 1)) begin
                wr_x_d              = '0;
                wr_bank_d           = ~wr_bank_q;
                wr_y_d              = wr_y_q + YW'(1);
                full_set[wr_bank_q] = 1'b1;
            end else begin
                wr_x_d = wr_x_q + XW'(1);
            end
        end
    end

    // Bank full flags and the registered ready, both from next-state values.
    always_comb begin
        if (vsync_rise) begin
            full_d = 2'b00;
        end else begin
            full_d = (full_q | full_set) & ~full_clr;
        end
        ready_d = armed_d && (wr_y_d < YW'(VACT_IN)) && !full_d[wr_bank_d];
    end

    // Reader FSM: next state, counters and the output pipeline stage.
    always_comb begin
        state_d       = state_q;
        rd_bank_d     = rd_bank_q;
        rd_x_d        = rd_x_q;
        rep_d         = rep_q;
        row_rep_d     = row_rep_q;
        blank_cnt_d   = blank_cnt_q;
        frame_start_d = frame_start_q;
        full_clr      = 2'b00;
        de_d          = 1'b0;
        vs_d          = 1'b0;
        hs_d          = 1'b0;
        pix_d         = '0;

        case (state_q)
            RD_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d   = RD_ACTIVE;
                    rd_x_d    = '0;
                    rep_d     = 2'd0;
                    row_rep_d = 2'd0;
                end
            end
            RD_ACTIVE: begin
                de_d          = 1'b1;
                vs_d          = frame_start_q;
                frame_start_d = 1'b0;
                pix_d         = line_mem[rd_bank_q][rd_x_q];
                if (rep_q == 2'd2) begin
                    rep_d = 2'd0;
                    if (rd_x_q == XW'(HACT_IN - 1)) begin
                        rd_x_d      = '0;
                        blank_cnt_d = '0;
                        state_d     = RD_BLANK;
                    end else begin
                        rd_x_d = rd_x_q + XW'(1);
                    end
                end else begin
                    rep_d = rep_q + 2'd1;
                end
            end
            RD_BLANK: begin
                hs_d = (blank_cnt_q == '0);
                if (blank_cnt_q == BW'(HBLANK - 1)) begin
                    blank_cnt_d = '0;
                    if (row_rep_q != 2'd2) begin
                        row_rep_d = row_rep_q + 2'd1;
                        rd_x_d    = '0;
                        rep_d     = 2'd0;
                        state_d   = RD_ACTIVE;
                    end else begin
                        row_rep_d           = 2'd0;
                        full_clr[rd_bank_q] = 1'b1;
                        rd_bank_d           = ~rd_bank_q;
                        state_d             = RD_IDLE;
                    end
                end else begin
                    blank_cnt_d = blank_cnt_q + BW'(1);
                end
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase

        // A frame-start edge abandons whatever the reader was doing.
        if (vsync_rise) begin
            state_d       = RD_IDLE;
            rd_bank_d     = 1'b0;
            rd_x_d        = '0;
            rep_d         = 2'd0;
            row_rep_d     = 2'd0;
            blank_cnt_d   = '0;
            frame_start_d = 1'b1;
            full_clr      = 2'b00;
            de_d          = 1'b0;
            vs_d          = 1'b0;
            hs_d          = 1'b0;
            pix_d         = '0;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vsync_prev_q  <= 1'b0;
            armed_q       <= 1'b0;
            wr_bank_q     <= 1'b0;
            wr_x_q        <= '0;
            wr_y_q        <= '0;
            full_q        <= 2'b00;
            ready_q       <= 1'b0;
            state_q       <= RD_IDLE;
            rd_bank_q     <= 1'b0;
            rd_x_q        <= '0;
            rep_q         <= 2'd0;
            row_rep_q     <= 2'd0;
            blank_cnt_q   <= '0;
            frame_start_q <= 1'b0;
            de_q          <= 1'b0;
            vs_q          <= 1'b0;
            hs_q          <= 1'b0;
            pix_q         <= '0;
        end else begin
            vsync_prev_q  <= vsync_prev_d;
            armed_q       <= armed_d;
            wr_bank_q     <= wr_bank_d;
            wr_x_q        <= wr_x_d;
            wr_y_q        <= wr_y_d;
            full_q        <= full_d;
            ready_q       <= ready_d;
            state_q       <= state_d;
            rd_bank_q     <= rd_bank_d;
            rd_x_q        <= rd_x_d;
            rep_q         <= rep_d;
            row_rep_q     <= row_rep_d;
            blank_cnt_q   <= blank_cnt_d;
            frame_start_q <= frame_start_d;
            de_q          <= de_d;
            vs_q          <= vs_d;
            hs_q          <= hs_d;
            pix_q         <= pix_d;
        end
    end

endmodule
